aq_jpeg_hdr_gen: RTL
====================

// Module: aq_jpeg_hdr_gen
// PURPOSE
//  Baseline JPEG header writer; the encode-side counterpart of the decoder marker parser.
//  On Start it emits SOI, DQT, SOF0, DHT and SOS as a byte stream with valid/ready.
//  Table bytes come from external quant/Huffman RAMs, so the stream round-trips through the decoder FSM.
//  EoiReq emits the EOI trailer after the entropy data.
// PARAMETERS
//  none (8-bit precision, baseline SOF0 only)
// PORTS
//  clk       in   1   single clock; all state on rising edge
//  rst       in   1   asynchronous, active-high reset
//  Start     in   1   1-cycle request; ignored while Busy
//  EoiReq    in   1   1-cycle request to emit FF D9; ignored while Busy
//  Width     in  16   image width, latched on Start
//  Height    in  16   image height, latched on Start
//  Comp      in   3   1 = grayscale; any other value = 3-component YCbCr
//  SubW      in   2   Y horizontal factor (1 or 2)
//  SubH      in   2   Y vertical factor (1 or 2)
//  QtAddr    out  7   {table, zigzag index[5:0]} to quant RAM
//  QtData    in   8   quant RAM data, 1-cycle read latency
//  HtAddr    out 10   {sel[1:0], idx[7:0]}; sel 00=DC0 01=AC0 10=DC1 11=AC1; idx 0-15 BITS, 16+ values
//  HtData    in   8   Huffman RAM data, 1-cycle read latency
//  OutData   out  8   stream byte
//  OutValid  out  1   OutData valid
//  OutReady  in   1   sink accepts; a byte transfers when OutValid & OutReady
//  Busy      out  1   high from Start/EoiReq accept until Done
//  Done      out  1   1-cycle pulse after the last byte transfers
// BEHAVIOUR
//  Reset: OutValid=0, Busy=0, Done=0, OutData=0, QtAddr=0, HtAddr=0; FSM returns to IDLE.
//   Reset mid-stream drops OutValid immediately and produces no Done.
//  Handshake: once OutValid rises, OutData and OutValid hold stable until OutReady.
//   No byte is ever skipped or repeated.
//  Latency: OutValid rises the cycle after Start or EoiReq is sampled.
//   Done pulses the cycle after the final handshake; Busy falls with Done.
//  Start and EoiReq high together: Start wins.
//  Throughput:
//   Fixed header bytes: 1 per cycle while OutReady=1.
//   RAM-sourced bytes: at least 1 per 2 cycles.
//  FSM:
//   IDLE -> SOI -> DQT(x Nq) -> SOF -> DHT_SUM -> DHT(x Nh) -> SOS -> DONE -> IDLE
//   IDLE -> EOI -> DONE
//  Counts: gray Nq=1, Nh=2 (DC0, AC0); colour Nq=2, Nh=4 (DC0, AC0, DC1, AC1).
//  SOI: FF D8.
//  DQT (per table t): FF DB 00 43 0t, then 64 QtData bytes at QtAddr={t,0..63}.
//  SOF: FF C0 Lh Ll 08 Hh Hl Wh Wl Nf, L=8+3*Nf.
//   Per component: id (1..Nf), {H,V}, Tq.
//   Y uses {SubW,SubH} and Tq=0; Cb/Cr use 11 and Tq=1.
//  DHT_SUM: before each DHT, read BITS idx 0-15 and sum into N (9-bit; max 256).
//   No output during DHT_SUM.
//  DHT: FF C4, L=19+N as 16-bit, class/id byte (00,10,01,11 per sel), 16 BITS, N values.
//   N=0 is legal: the segment then has no value bytes.
//  SOS: FF DA, L=6+2*Ns, Ns.
//   Per component: id then Td/Ta (Y 00, chroma 11); then 00 3F 00.
//  Inputs latched on Start; later input changes do not affect the stream in flight.
//  SubW/SubH values outside 1-2 are emitted unchanged; no checking.
// TESTING
//  1 Gray 16x8; each Huffman table BITS[0]=1, others 0, value 00; quant RAM = index -> 138 bytes.
//    SOF = FF C0 00 0B 08 00 08 00 10 01 01 11 00; each DHT L=0x0014.
//  2 Colour 640x480, SubW=SubH=2, same tables -> 261 bytes.
//    SOF = FF C0 00 11 08 01 E0 02 80 03 01 22 00 02 11 01 03 11 01;
//    SOS = FF DA 00 0C 03 01 00 02 11 03 11 00 3F 00.
//  3 Case 2 with OutReady random (~50%) -> byte sequence identical to the OutReady=1 run;
//    OutData is never changed while stalled.
//  4 AC0 BITS all 0x10 (N=256) -> DHT L=0x0113, 256 value bytes read from idx 16..271 range clamped per sel.
//  5 EoiReq in IDLE -> FF D9, then Done 1 cycle after the second handshake;
//    Start in the same cycle as EoiReq -> header only.
//  6 rst asserted mid-DQT -> OutValid=0 immediately, no Done;
//    a following Start yields a complete, correct stream.

Source files
------------

// File: rtl/aq_jpeg_hdr_gen.sv
// aq_jpeg_hdr_gen
//   Baseline JPEG header writer. Start emits SOI, DQT (1 or 2 tables),
//   SOF0, DHT (2 or 4 tables) and SOS as a valid/ready byte stream.
//   Quant and Huffman table bytes are read from external synchronous RAMs
//   with one cycle of read latency. EoiReq emits the FF D9 trailer.
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   Start, EoiReq     1-cycle requests, ignored while Busy (Start wins)
//   Width, Height     image size, latched on Start
//   Comp              1 = grayscale, otherwise 3-component YCbCr
//   SubW, SubH        Y sampling factors, emitted unchanged
//   QtAddr/QtData     quant RAM port, address {table, zigzag index}
//   HtAddr/HtData     Huffman RAM port, address {sel, idx}
//   OutData/OutValid/OutReady   byte stream
//   Busy              high from request accept until Done
//   Done              1-cycle pulse after the last byte transfers
module aq_jpeg_hdr_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic        EoiReq,
    input  logic [15:0] Width,
    input  logic [15:0] Height,
    input  logic [2:0]  Comp,
    input  logic [1:0]  SubW,
    input  logic [1:0]  SubH,
    output logic [6:0]  QtAddr,
    input  logic [7:0]  QtData,
    output logic [9:0]  HtAddr,
    input  logic [7:0]  HtData,
    output logic [7:0]  OutData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [3:0] {IDLE, SOI, DQT, SOF, DHT_SUM, DHT, SOS, EOI, DONE} state_t;

    state_t      state;
    logic [8:0]  cnt;      // byte position inside the current segment
    logic [1:0]  tbl;      // current quant table / Huffman sel
    logic [8:0]  hufN;     // number of Huffman values of the current table
    logic        ramRdy;   // RAM address stable long enough for data to be valid
    logic [15:0] wid, hgt;
    logic        colour;
    logic [1:0]  subW, subH;

    logic [7:0]  fixByte;
    logic [7:0]  ramByte;
    logic [8:0]  lastPos;
    logic        isRam;
    logic [15:0] dhtLen;
    logic [7:0]  nf;

    // Value bytes beyond idx 255 cannot be addressed; they repeat the last entry.
    function automatic logic [7:0] clampIdx(input logic [8:0] v);
        return v[8] ? 8'hFF : v[7:0];
    endfunction

    // Byte selection for the segment position currently being loaded.
    always_comb begin
        nf      = colour ? 8'd3 : 8'd1;
        dhtLen  = 16'd19 + {7'd0, hufN};
        fixByte = 8'h00;
        ramByte = HtData;
        lastPos = 9'd0;
        isRam   = 1'b0;
        case (state)
            SOI: begin
                lastPos = 9'd1;
                fixByte = (cnt == 9'd0) ? 8'hFF : 8'hD8;
            end
            EOI: begin
                lastPos = 9'd1;
                fixByte = (cnt == 9'd0) ? 8'hFF : 8'hD9;
            end
            DQT: begin
                lastPos = 9'd68;
                isRam   = (cnt >= 9'd5);
                ramByte = QtData;
                case (cnt)
                    9'd0:    fixByte = 8'hFF;
                    9'd1:    fixByte = 8'hDB;
                    9'd2:    fixByte = 8'h00;
                    9'd3:    fixByte = 8'h43;
                    9'd4:    fixByte = {6'd0, tbl};
                    default: fixByte = 8'h00;
                endcase
            end
            SOF: begin
                lastPos = colour ? 9'd18 : 9'd12;
                case (cnt)
                    9'd0:    fixByte = 8'hFF;
                    9'd1:    fixByte = 8'hC0;
                    9'd2:    fixByte = 8'h00;
                    9'd3:    fixByte = colour ? 8'h11 : 8'h0B;
                    9'd4:    fixByte = 8'h08;
                    9'd5:    fixByte = hgt[15:8];
                    9'd6:    fixByte = hgt[7:0];
                    9'd7:    fixByte = wid[15:8];
                    9'd8:    fixByte = wid[7:0];
                    9'd9:    fixByte = nf;
                    9'd10:   fixByte = 8'h01;
                    9'd11:   fixByte = {2'b00, subW, 2'b00, subH};
                    9'd12:   fixByte = 8'h00;
                    9'd13:   fixByte = 8'h02;
                    9'd14:   fixByte = 8'h11;
                    9'd15:   fixByte = 8'h01;
                    9'd16:   fixByte = 8'h03;
                    9'd17:   fixByte = 8'h11;
                    9'd18:   fixByte = 8'h01;
                    default: fixByte = 8'h00;
                endcase
            end
            DHT: begin
                lastPos = 9'd20 + hufN;
                isRam   = (cnt >= 9'd5);
                case (cnt)
                    9'd0:    fixByte = 8'hFF;
                    9'd1:    fixByte = 8'hC4;
                    9'd2:    fixByte = dhtLen[15:8];
                    9'd3:    fixByte = dhtLen[7:0];
                    // sel 00,01,10,11 -> class/id 00,10,01,11
                    9'd4:    fixByte = {3'b000, tbl[0], 3'b000, tbl[1]};
                    default: fixByte = 8'h00;
                endcase
            end
            SOS: begin
                lastPos = colour ? 9'd13 : 9'd9;
                case (cnt)
                    9'd0:    fixByte = 8'hFF;
                    9'd1:    fixByte = 8'hDA;
                    9'd2:    fixByte = 8'h00;
                    9'd3:    fixByte = colour ? 8'h0C : 8'h08;
                    9'd4:    fixByte = nf;
                    9'd5:    fixByte = 8'h01;
                    9'd6:    fixByte = 8'h00;
                    9'd7:    fixByte = colour ? 8'h02 : 8'h00;
                    9'd8:    fixByte = colour ? 8'h11 : 8'h3F;
                    9'd9:    fixByte = colour ? 8'h03 : 8'h00;
                    9'd10:   fixByte = 8'h11;
                    9'd11:   fixByte = 8'h00;
                    9'd12:   fixByte = 8'h3F;
                    9'd13:   fixByte = 8'h00;
                    default: fixByte = 8'h00;
                endcase
            end
            default: ;
        endcase
    end

    // NOTE: every register, including the latched image parameters, is reset so
    // that no X can reach the stream after a mid-stream reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            tbl      <= '0;
            hufN     <= '0;
            ramRdy   <= 1'b0;
            wid      <= '0;
            hgt      <= '0;
            colour   <= 1'b0;
            subW     <= '0;
            subH     <= '0;
            QtAddr   <= '0;
            HtAddr   <= '0;
            OutData  <= '0;
            OutValid <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; later assignments in this block
            // deliberately override the defaults and the address advance below.
            ramRdy <= 1'b1;
            Done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        wid      <= Width;
                        hgt      <= Height;
                        colour   <= (Comp != 3'd1);
                        subW     <= SubW;
                        subH     <= SubH;
                        OutData  <= 8'hFF;
                        OutValid <= 1'b1;
                        cnt      <= 9'd1;
                        Busy     <= 1'b1;
                        state    <= SOI;
                    end else if (EoiReq) begin
                        OutData  <= 8'hFF;
                        OutValid <= 1'b1;
                        cnt      <= 9'd1;
                        Busy     <= 1'b1;
                        state    <= EOI;
                    end
                end
                DHT_SUM: begin
                    // Let the previous segment's last byte drain; emit nothing new.
                    if (OutValid && OutReady)
                        OutValid <= 1'b0;
                    if (ramRdy) begin
                        hufN   <= hufN + {1'b0, HtData};
                        ramRdy <= 1'b0;
                        if (cnt == 9'd15) begin
                            cnt    <= '0;
                            HtAddr <= {tbl, 8'd0};
                            state  <= DHT;
                        end else begin
                            cnt    <= cnt + 9'd1;
                            HtAddr <= {tbl, cnt[7:0] + 8'd1};
                        end
                    end
                end
                DONE: begin
                    if (!OutValid || OutReady) begin
                        OutValid <= 1'b0;
                        Done     <= 1'b1;
                        Busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    if (!OutValid || OutReady) begin
                        if (isRam && !ramRdy) begin
                            OutValid <= 1'b0;
                        end else begin
                            OutData  <= isRam ? ramByte : fixByte;
                            OutValid <= 1'b1;
                            cnt      <= cnt + 9'd1;
                            // Point the RAM at the next byte of this segment.
                            if (isRam) begin
                                ramRdy <= 1'b0;
                                if (state == DQT)
                                    QtAddr <= {tbl[0], cnt[5:0] - 6'd4};
                                else
                                    HtAddr <= {tbl, clampIdx(cnt - 9'd4)};
                            end
                            if (cnt == lastPos) begin
                                cnt <= '0;
                                case (state)
                                    SOI: begin
                                        tbl    <= '0;
                                        QtAddr <= '0;
                                        ramRdy <= 1'b0;
                                        state  <= DQT;
                                    end
                                    DQT: begin
                                        if (tbl == (colour ? 2'd1 : 2'd0)) begin
                                            state <= SOF;
                                        end else begin
                                            tbl    <= tbl + 2'd1;
                                            QtAddr <= {1'b1, 6'd0};
                                            ramRdy <= 1'b0;
                                        end
                                    end
                                    SOF: begin
                                        tbl    <= '0;
                                        hufN   <= '0;
                                        HtAddr <= '0;
                                        ramRdy <= 1'b0;
                                        state  <= DHT_SUM;
                                    end
                                    DHT: begin
                                        if (tbl == (colour ? 2'd3 : 2'd1)) begin
                                            state <= SOS;
                                        end else begin
                                            tbl    <= tbl + 2'd1;
                                            hufN   <= '0;
                                            HtAddr <= {tbl + 2'd1, 8'd0};
                                            ramRdy <= 1'b0;
                                            state  <= DHT_SUM;
                                        end
                                    end
                                    default: state <= DONE;
                                endcase
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
